l1a_cmd_decoder: RTL and testbench
==================================

# l1a_cmd_decoder

Parametrised serial trigger-command decoder for the OFC trigger input line. It locks onto the 1-bit command stream after a run of idle zeros, then frames each command as a start bit, CMD_BITS command bits (MSB first) and an optional even-parity bit. Valid commands become single-cycle strobes (L1A, PS, PL1A, ALIGN, DELTA, RST) plus a generic code/one-hot output. It adds parity checking, error and frame counters, and lock-loss recovery, and sits between the SFP/trigger receive bit and the trigger/readout control logic.

## Interface
- CMD_BITS, 3: command field width, must be ≥3.
- IDLE_LOCK, 4: consecutive zeros needed to acquire lock, ≥1.
- PARITY_EN, 1: 1 means an even-parity bit follows the command field; 0 means no parity bit.
- MAX_ERR, 4: consecutive parity errors that drop lock, ≥1.
- CNT_W, 16: width of the frame and error counters.
- clk  in  1  system clock; one line bit per cycle.
- rst  in  1  asynchronous, active-high reset.
- in  in  1  serial command line.
- cmd_valid  out  1  one-cycle pulse when a good frame is decoded.
- cmd_code  out  CMD_BITS  decoded command; holds its last value between frames.
- cmd_onehot  out  2**CMD_BITS  one-hot of cmd_code, high only while cmd_valid is high.
- L1A, PS, PL1A, ALIGN, DELTA, RST  out  1 each  one-cycle strobes decoded from cmd_code[2:0].
- locked  out  1  high while framing is acquired.
- parity_err  out  1  one-cycle pulse on a bad-parity frame.
- frame_cnt  out  CNT_W  good-frame count; wraps modulo 2**CNT_W.
- err_cnt  out  CNT_W  parity-error count; saturates at all-ones.

## Operation
- Input register: `in` is registered into in_q on every edge. The FSM uses only in_q.
- Reset (asynchronous) clears all outputs, counters, in_q and the shift register to 0, sets the state to HUNT, and clears the zero and consecutive-error counters.
- HUNT
  - Counts consecutive in_q==0; any 1 clears the count.
  - When the count reaches IDLE_LOCK: set locked=1 and go to IDLE.
- IDLE
  - in_q==1 is a start bit: go to SHIFT with the bit counter at 0. in_q==0 stays in IDLE.
- SHIFT
  - Shifts in_q into the command shift register, MSB first, for CMD_BITS cycles.
  - Then goes to PAR if PARITY_EN=1, else to DECODE.
- PAR
  - Samples one parity bit. The frame is good when XOR(command bits, parity bit) = 0.
  - Then goes to DECODE.
- DECODE (1 cycle, always followed by IDLE)
  - Good frame:
    - load cmd_code; pulse cmd_valid, cmd_onehot and the named strobe(s);
    - frame_cnt += 1; clear the consecutive-error count.
  - Bad frame:
    - no strobes and cmd_code is unchanged; pulse parity_err;
    - err_cnt += 1 (saturating); consecutive-error count += 1;
    - if that count reaches MAX_ERR: locked=0, go to HUNT, zero counter=0, consecutive count cleared.
- Strobe map on cmd_code[2:0]:
  - 000 → L1A; 001 → DELTA; 010 → ALIGN; 100 → L1A+PS; 110 → PL1A; 111 → RST.
  - 011 and 101 → cmd_valid/cmd_onehot only, no named strobe.
  - Upper bits (CMD_BITS>3) are ignored by the named strobes.
- Back-to-back frames are legal: the start bit of the next frame may arrive on the line bit immediately after the last bit of the previous frame. DECODE overlaps with that bit, and it is accepted.
- The frame length F = 1 + CMD_BITS + PARITY_EN line bits.

## Timing
- Latency: if the last frame bit is on `in` at edge E, then in_q captures it at E, the FSM consumes it at E+1, and the strobes, cmd_valid, cmd_onehot and parity_err are high from E+2 to E+3, exactly one cycle.
- cmd_code updates at E+2. frame_cnt and err_cnt update at E+2.
- locked rises at the edge where the IDLE_LOCK-th zero is consumed from in_q. It falls at the same edge that asserts the MAX_ERR-th parity_err.
- Strobe outputs are registered; none is combinational from `in`.
- Reset asserted mid-frame discards the frame and causes no strobe. After release, the block needs IDLE_LOCK zeros before any frame is accepted.
- With PARITY_EN=0, parity_err and err_cnt stay at 0 permanently.

## Test plan
- Lock and single command (defaults): rst, then 6 zeros, then bits 1,0,0,0,0 → locked high after the 4th zero. L1A one-cycle pulse 2 edges after the last bit. cmd_code=000, frame_cnt=1.
- Full map: locked, send codes 000–111 back-to-back with correct parity → the exact strobe set per code (100 → L1A+PS; 011/101 → cmd_valid only). 8 cmd_valid pulses at spacing F=5 cycles, frame_cnt=8.
- Parity error: send 1,1,1,1,0 (bad parity) → no RST, parity_err pulse, err_cnt=1, cmd_code unchanged. A following good 110 → PL1A and the consecutive-error count cleared.
- Lock loss: 4 consecutive bad frames → locked falls with the 4th parity_err. A good-format frame before 4 zeros → no strobe. After 4 zeros, relock and decode normally.
- Pre-lock and reset: a 1 during HUNT restarts the zero count (3 zeros, 1, 3 zeros → still unlocked). rst asserted mid-SHIFT → all outputs 0 immediately, no strobe after release.
- Parameter variant: CMD_BITS=5, PARITY_EN=0, IDLE_LOCK=8 → F=6. Code 10110 drives PL1A (low bits 110) and cmd_onehot bit 22. err_cnt stays 0.

Source files
------------

// File: rtl/l1a_cmd_decoder.sv
// Serial trigger-command decoder: locks on idle zeros, frames start/command/parity
// bits and emits registered single-cycle command strobes plus frame/error counters.
module l1a_cmd_decoder #(
    parameter int CMD_BITS  = 3,
    parameter int IDLE_LOCK = 4,
    parameter int PARITY_EN = 1,
    parameter int MAX_ERR   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in,
    output logic                     cmd_valid,
    output logic [CMD_BITS-1:0]      cmd_code,
    output logic [(2**CMD_BITS)-1:0] cmd_onehot,
    output logic                     L1A,
    output logic                     PS,
    output logic                     PL1A,
    output logic                     ALIGN,
    output logic                     DELTA,
    output logic                     RST,
    output logic                     locked,
    output logic                     parity_err,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [CNT_W-1:0]         err_cnt
);
    localparam int NCODE = 2**CMD_BITS;
    localparam int ZW    = $clog2(IDLE_LOCK + 1);
    localparam int BW    = $clog2(CMD_BITS);
    localparam int EW    = $clog2(MAX_ERR + 1);

    localparam logic [2:0] HUNT   = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] SHIFT  = 3'd2;
    localparam logic [2:0] PAR    = 3'd3;
    localparam logic [2:0] DECODE = 3'd4;

    logic [2:0]          state;
    logic                in_q;
    logic                in_vld;
    logic [CMD_BITS-1:0] shreg;
    logic                par_q;
    logic [ZW-1:0]       zcnt;
    logic [BW-1:0]       bcnt;
    logic [EW-1:0]       ecnt;
    logic                good;

    // Returns {L1A, PS, PL1A, ALIGN, DELTA, RST} for the low three code bits.
    function automatic logic [5:0] strobe_map(input logic [2:0] c);
        case (c)
            3'b000:  strobe_map = 6'b100000;
            3'b001:  strobe_map = 6'b000010;
            3'b010:  strobe_map = 6'b000100;
            3'b100:  strobe_map = 6'b110000;
            3'b110:  strobe_map = 6'b001000;
            3'b111:  strobe_map = 6'b000001;
            default: strobe_map = 6'b000000;
        endcase
    endfunction

    assign good = (PARITY_EN == 0) || !((^shreg) ^ par_q);

    // in_vld keeps the reset value of in_q from being counted as a line zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            in_q       <= 1'b0;
            in_vld     <= 1'b0;
            shreg      <= '0;
            par_q      <= 1'b0;
            zcnt       <= '0;
            bcnt       <= '0;
            ecnt       <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            cmd_onehot <= '0;
            {L1A, PS, PL1A, ALIGN, DELTA, RST} <= 6'b0;
            locked     <= 1'b0;
            parity_err <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            in_q       <= in;
            in_vld     <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_onehot <= '0;
            {L1A, PS, PL1A, ALIGN, DELTA, RST} <= 6'b0;
            parity_err <= 1'b0;
            if (in_vld) begin
                case (state)
                    HUNT: begin
                        if (in_q) begin
                            zcnt <= '0;
                        end else if (zcnt == ZW'(IDLE_LOCK - 1)) begin
                            zcnt   <= '0;
                            locked <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            zcnt <= zcnt + 1'b1;
                        end
                    end
                    IDLE: begin
                        bcnt <= '0;
                        if (in_q) state <= SHIFT;
                    end
                    SHIFT: begin
                        shreg <= {shreg[CMD_BITS-2:0], in_q};
                        bcnt  <= bcnt + 1'b1;
                        if (bcnt == BW'(CMD_BITS - 1))
                            state <= (PARITY_EN != 0) ? PAR : DECODE;
                    end
                    PAR: begin
                        par_q <= in_q;
                        state <= DECODE;
                    end
                    DECODE: begin
                        // The line bit consumed here may already be the next start bit.
                        bcnt  <= '0;
                        state <= in_q ? SHIFT : IDLE;
                        if (good) begin
                            cmd_valid  <= 1'b1;
                            cmd_code   <= shreg;
                            cmd_onehot <= NCODE'(1) << shreg;
                            {L1A, PS, PL1A, ALIGN, DELTA, RST} <= strobe_map(shreg[2:0]);
                            frame_cnt  <= frame_cnt + 1'b1;
                            ecnt       <= '0;
                        end else begin
                            parity_err <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                            if (ecnt == EW'(MAX_ERR - 1)) begin
                                ecnt   <= '0;
                                zcnt   <= '0;
                                locked <= 1'b0;
                                state  <= HUNT;
                            end else begin
                                ecnt <= ecnt + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_l1a_cmd_decoder.sv
// Bench for l1a_cmd_decoder: default instance plus a CMD_BITS=5/no-parity/IDLE_LOCK=8
// instance, both checked every cycle against a frame-level reference model.
module tb_l1a_cmd_decoder;
    logic clk, rst, in0, in1;

    logic        v0, l1a0, ps0, pl1a0, al0, de0, rs0, lk0, pe0;
    logic [2:0]  code0;
    logic [7:0]  oh0;
    logic [15:0] fc0, ec0;
    logic        v1, l1a1, ps1, pl1a1, al1, de1, rs1, lk1, pe1;
    logic [4:0]  code1;
    logic [31:0] oh1;
    logic [15:0] fc1, ec1;

    l1a_cmd_decoder dut0 (
        .clk(clk), .rst(rst), .in(in0), .cmd_valid(v0), .cmd_code(code0), .cmd_onehot(oh0),
        .L1A(l1a0), .PS(ps0), .PL1A(pl1a0), .ALIGN(al0), .DELTA(de0), .RST(rs0),
        .locked(lk0), .parity_err(pe0), .frame_cnt(fc0), .err_cnt(ec0)
    );

    l1a_cmd_decoder #(.CMD_BITS(5), .IDLE_LOCK(8), .PARITY_EN(0), .MAX_ERR(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in(in1), .cmd_valid(v1), .cmd_code(code1), .cmd_onehot(oh1),
        .L1A(l1a1), .PS(ps1), .PL1A(pl1a1), .ALIGN(al1), .DELTA(de1), .RST(rs1),
        .locked(lk1), .parity_err(pe1), .frame_cnt(fc1), .err_cnt(ec1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int P_CB [2] = '{3, 5};
    localparam int P_IL [2] = '{4, 8};
    localparam int P_PE [2] = '{1, 0};
    localparam int P_ME [2] = '{4, 4};

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model state, per instance
    bit          m_lk[2], m_inframe[2], m_pend[2];
    int          m_zeros[2], m_nb[2], m_code[2], m_ones[2], m_pcode[2], m_pones[2], m_cons[2];
    bit          e_valid[2], e_perr[2];
    logic [5:0]  e_str[2];
    logic [63:0] e_oh[2];
    int          e_code[2], e_fcnt[2], e_ecnt[2];

    logic q0[$];
    logic q1[$];
    logic pb0, pb1;
    bit   pv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // {L1A, PS, PL1A, ALIGN, DELTA, RST}
    function automatic logic [5:0] exp_str(input int c);
        case (c % 8)
            0: return 6'b100000;
            1: return 6'b000010;
            2: return 6'b000100;
            4: return 6'b110000;
            6: return 6'b001000;
            7: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lk[i] = 0; m_inframe[i] = 0; m_pend[i] = 0;
            m_zeros[i] = 0; m_nb[i] = 0; m_code[i] = 0; m_ones[i] = 0;
            m_pcode[i] = 0; m_pones[i] = 0; m_cons[i] = 0;
            e_valid[i] = 0; e_perr[i] = 0; e_str[i] = '0; e_oh[i] = '0;
            e_code[i] = 0; e_fcnt[i] = 0; e_ecnt[i] = 0;
        end
        pv = 0;
    endtask

    // One clock of the model: a finished frame is judged one bit-time after its last bit.
    task automatic model_step(input int i, input logic b, input bit vb);
        bit ok;
        e_valid[i] = 0; e_perr[i] = 0; e_str[i] = '0; e_oh[i] = '0;
        if (m_pend[i]) begin
            m_pend[i] = 0;
            ok = (P_PE[i] == 0) || (m_pones[i] % 2 == 0);
            if (ok) begin
                e_valid[i] = 1;
                e_code[i]  = m_pcode[i];
                e_oh[i]    = 64'd1 << m_pcode[i];
                e_str[i]   = exp_str(m_pcode[i]);
                e_fcnt[i]  = (e_fcnt[i] + 1) % 65536;
                m_cons[i]  = 0;
            end else begin
                e_perr[i] = 1;
                if (e_ecnt[i] < 65535) e_ecnt[i]++;
                m_cons[i]++;
                if (m_cons[i] == P_ME[i]) begin
                    m_lk[i] = 0; m_zeros[i] = 0; m_cons[i] = 0;
                    return;
                end
            end
        end
        if (!vb) return;
        if (!m_lk[i]) begin
            if (b == 1'b0) begin
                m_zeros[i]++;
                if (m_zeros[i] == P_IL[i]) begin
                    m_lk[i] = 1; m_zeros[i] = 0;
                end
            end else begin
                m_zeros[i] = 0;
            end
        end else if (m_inframe[i]) begin
            m_nb[i]++;
            m_ones[i] += int'(b);
            if (m_nb[i] <= P_CB[i]) m_code[i] = m_code[i] * 2 + int'(b);
            if (m_nb[i] == P_CB[i] + P_PE[i]) begin
                m_pend[i] = 1; m_inframe[i] = 0;
                m_pcode[i] = m_code[i]; m_pones[i] = m_ones[i];
            end
        end else if (b) begin
            m_inframe[i] = 1; m_nb[i] = 0; m_code[i] = 0; m_ones[i] = 0;
        end
    endtask

    task automatic compare_all();
        chk("flags0", {lk0, pe0, v0, l1a0, ps0, pl1a0, al0, de0, rs0},
            {m_lk[0], e_perr[0], e_valid[0], e_str[0]});
        chk("code0", code0, e_code[0]);
        chk("onehot0", oh0, e_oh[0]);
        chk("fcnt0", fc0, e_fcnt[0]);
        chk("ecnt0", ec0, e_ecnt[0]);
        chk("flags1", {lk1, pe1, v1, l1a1, ps1, pl1a1, al1, de1, rs1},
            {m_lk[1], e_perr[1], e_valid[1], e_str[1]});
        chk("code1", code1, e_code[1]);
        chk("onehot1", oh1, e_oh[1]);
        chk("fcnt1", fc1, e_fcnt[1]);
        chk("ecnt1", ec1, e_ecnt[1]);
    endtask

    // Called at a negedge: drive bits, advance one clock, compare at the next negedge.
    task automatic cyc(input logic b0, input logic b1);
        in0 = b0;
        in1 = b1;
        @(posedge clk);
        model_step(0, pb0, pv);
        model_step(1, pb1, pv);
        pb0 = b0;
        pb1 = b1;
        pv  = 1;
        @(negedge clk);
        compare_all();
    endtask

    task automatic push_bit(input int i, input logic b);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic push_zeros(input int i, input int n);
        for (int k = 0; k < n; k++) push_bit(i, 1'b0);
    endtask

    task automatic push_frame(input int i, input int code, input bit bad);
        logic par;
        logic b;
        par = 1'b0;
        push_bit(i, 1'b1);
        for (int k = P_CB[i] - 1; k >= 0; k--) begin
            b = logic'((code >> k) & 1);
            par ^= b;
            push_bit(i, b);
        end
        if (P_PE[i] != 0) push_bit(i, par ^ logic'(bad));
    endtask

    task automatic run();
        logic b0, b1;
        while (q0.size() > 0 || q1.size() > 0) begin
            b0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
            b1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
            cyc(b0, b1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out0"}, {lk0, pe0, v0, l1a0, ps0, pl1a0, al0, de0, rs0, code0, oh0}, '0);
        chk({tag, "_cnt0"}, {fc0, ec0}, '0);
        chk({tag, "_out1"}, {lk1, pe1, v1, l1a1, ps1, pl1a1, al1, de1, rs1, code1, oh1}, '0);
        chk({tag, "_cnt1"}, {fc1, ec1}, '0);
    endtask

    task automatic apply_reset();
        in0 = 1'b0;
        in1 = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in0 = 1'b0; in1 = 1'b0; pb0 = 1'b0; pb1 = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Lock and a single L1A
        push_zeros(0, 6); push_frame(0, 0, 0); push_zeros(0, 3);
        run();
        chk("t1_fcnt", fc0, 16'd1);
        chk("t1_code", code0, 3'd0);

        // Full command map back-to-back
        for (int c = 0; c < 8; c++) push_frame(0, c, 0);
        push_zeros(0, 3);
        run();
        chk("t2_fcnt", fc0, 16'd9);
        chk("t2_code", code0, 3'd7);

        // Bad-parity RST frame followed by a good PL1A
        push_frame(0, 7, 1); push_frame(0, 6, 0); push_zeros(0, 3);
        run();
        chk("t3_ecnt", ec0, 16'd1);
        chk("t3_fcnt", fc0, 16'd10);
        chk("t3_code", code0, 3'd6);

        // Lock loss after MAX_ERR bad frames; a frame before relock is ignored
        for (int k = 0; k < 4; k++) push_frame(0, 7, 1);
        push_frame(0, 2, 0);
        run();
        chk("t4_unlocked", lk0, 1'b0);
        chk("t4_ecnt", ec0, 16'd5);
        chk("t4_fcnt", fc0, 16'd10);
        push_zeros(0, 4); push_frame(0, 4, 0); push_frame(0, 7, 0); push_zeros(0, 3);
        run();
        chk("t4_relock_fcnt", fc0, 16'd12);

        // A one during hunt restarts the zero count
        apply_reset();
        push_zeros(0, 3); push_bit(0, 1'b1); push_zeros(0, 3);
        run();
        chk("t5_unlocked", lk0, 1'b0);

        // Reset in the middle of a frame
        push_zeros(0, 4); push_bit(0, 1'b1); push_bit(0, 1'b1); push_bit(0, 1'b0);
        run();
        #2;
        apply_reset();
        push_bit(0, 1'b1); push_bit(0, 1'b0); push_zeros(0, 3);
        run();
        chk("t5_no_frame", fc0, 16'd0);

        // Wide-code, no-parity instance
        push_zeros(1, 8); push_zeros(0, 4);
        run();
        push_frame(1, 22, 0); push_frame(1, 31, 0); push_frame(1, 8, 0); push_zeros(1, 3);
        run();
        chk("t6_fcnt1", fc1, 16'd3);
        chk("t6_code1", code1, 5'd8);
        chk("t6_ecnt1", ec1, 16'd0);

        // Randomized traffic on both instances
        for (int n = 0; n < 150; n++) begin
            push_zeros(0, $urandom_range(0, 2));
            push_frame(0, $urandom_range(0, 7), ($urandom_range(0, 9) == 0));
            push_zeros(1, $urandom_range(0, 2));
            push_frame(1, $urandom_range(0, 31), 1'b0);
            run();
        end
        push_zeros(0, 3);
        run();
        chk("final_ecnt1", ec1, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
